// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It owns the program counter, issues one read at a
// time to instruction memory using a req/ack handshake, and presents one
// instruction at a time to decode. Branch, jump and jump-register resolution
// can redirect the PC at any time. A fetch that was already in flight when
// the redirect arrived is on the wrong path, so its data is dropped.
//
// Parameters
//   RESET_PC     PC loaded on reset. It must be word aligned. Bits [1:0] are
//                forced to zero in any case.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   imem_req     read request. Stays high until imem_ack.
//   imem_addr    word-aligned read address. Stable while imem_req is high.
//   imem_ack     one-cycle acknowledge. imem_rdata is valid in that cycle.
//   imem_rdata   instruction word returned by memory
//   redirect     load redirect_pc as the next fetch PC
//   redirect_pc  redirect target. Bits [1:0] are ignored.
//   stall        decode cannot accept the presented instruction this cycle
//   instr_valid  instr, pc_out and pcplus4 are valid
//   instr        fetched instruction (op = instr[31:26], funct = instr[5:0])
//   pc_out       address of instr
//   pcplus4      pc_out + 4, modulo 2^32
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4
);

    // Fetch sequencing:
    //   FETCH_ARM  latch the next fetch address. No request this cycle.
    //   FETCH      request outstanding. Its data belongs to the current path.
    //   OUT        instruction presented to decode.
    //   FLUSH      request outstanding but on the wrong path. Wait for the
    //              ack and throw the data away.
    typedef enum logic [1:0] {
        FETCH_ARM = 2'd0,
        FETCH     = 2'd1,
        OUT       = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;              // next sequential fetch PC
    logic [31:0] req_addr, req_addr_nxt;  // address of the current request
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] pc_out_q, pc_out_nxt;

    // Mask the target rather than slicing it. That way all of redirect_pc
    // stays in the logic cone and the low bits are still forced to zero.
    logic [31:0] target_pc;
    assign target_pc = redirect_pc & WORD_MASK;

    // -----------------------------------------------------------------------
    // State and data registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever the order of the
    // statements.
    always_ff @(posedge clk) begin
        // NOTE: reset is tested inside the clocked block, so it acts only on
        // a rising edge. An imem_ack that arrives in the same cycle loses to
        // it.
        if (reset) begin
            state    <= FETCH_ARM;
            pc       <= RESET_PC_ALIGNED;
            req_addr <= RESET_PC_ALIGNED;
            instr_q  <= 32'h0000_0000;
            pc_out_q <= RESET_PC_ALIGNED;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            instr_q  <= instr_nxt;
            pc_out_q <= pc_out_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-data logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold value before the case statement.
        // A path that assigns nothing then keeps the register contents
        // instead of inferring a latch.
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        instr_nxt    = instr_q;
        pc_out_nxt   = pc_out_q;

        unique case (state)
            FETCH_ARM: begin
                // A redirect here takes effect at once. Nothing is in flight
                // yet, so the new target can be requested directly.
                if (redirect) begin
                    pc_nxt       = target_pc;
                    req_addr_nxt = target_pc;
                end else begin
                    req_addr_nxt = pc;
                end
                state_nxt = FETCH;
            end

            FETCH: begin
                if (imem_ack && !redirect) begin
                    instr_nxt  = imem_rdata;
                    pc_out_nxt = req_addr;
                    pc_nxt     = req_addr + 32'd4;
                    state_nxt  = OUT;
                end else if (imem_ack && redirect) begin
                    // The data arrives just as its path is killed. The
                    // request is complete, so re-arm on the new target.
                    pc_nxt    = target_pc;
                    state_nxt = FETCH_ARM;
                end else if (redirect) begin
                    // The memory cannot cancel a request. Keep it up, at the
                    // same address, until the ack, and drop the data.
                    pc_nxt    = target_pc;
                    state_nxt = FLUSH;
                end
            end

            OUT: begin
                // A redirect wins over stall. The presented instruction is
                // younger than the resolved branch and must not be held.
                if (redirect) begin
                    pc_nxt    = target_pc;
                    state_nxt = FETCH_ARM;
                end else if (!stall) begin
                    state_nxt = FETCH_ARM;
                end
            end

            FLUSH: begin
                // A later redirect replaces an earlier one.
                if (redirect) begin
                    pc_nxt = target_pc;
                end
                if (imem_ack) begin
                    state_nxt = FETCH_ARM;
                end
            end

            default: begin
                state_nxt = FETCH_ARM;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    // All outputs come straight from registers or from a decode of the state
    // register. There is no combinational path from any input to any output.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        unique case (state)
            FETCH:     imem_req    = 1'b1;
            FLUSH:     imem_req    = 1'b1;
            OUT:       instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    // The request address stays at req_addr through FLUSH as well. The
    // memory sees one stable request from start to ack.
    assign imem_addr = req_addr;
    assign instr     = instr_q;
    assign pc_out    = pc_out_q;
    assign pcplus4   = pc_out_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The driver runs one edge at a time. After
// each edge it updates a request-lifetime model of the fetch stage: whether a
// request is outstanding, whether that request is on a dead path, whether an
// instruction is being held for decode, and what the next PC is. The model
// works from the input values seen at that edge.
//
// On every falling edge one compare process checks all DUT outputs against
// the model. Each test also ends with literal expectations worked out by
// hand.
//
// Memory is a function of the address. The bench acknowledges automatically
// after a programmable number of wait cycles, and a test can override this.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pcplus4;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc_out      (pc_out),
        .pcplus4     (pcplus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Auto-ack memory: acknowledges once the request has been up for
    // ack_delay extra cycles.
    int ack_delay = 0;
    int wait_cnt  = 0;

    // Behavioural model state
    bit          m_req     = 1'b0;   // a request is outstanding
    bit          m_discard = 1'b0;   // outstanding request is on a dead path
    bit          m_valid   = 1'b0;   // an instruction is held for decode
    logic [31:0] m_addr    = 32'h0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instr   = 32'h0;
    logic [31:0] m_pc_out  = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h3C00_0A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge, seen from the outside: what must be true afterwards,
    // given the inputs that were present at the edge.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (reset) begin
            m_req     = 1'b0;
            m_discard = 1'b0;
            m_valid   = 1'b0;
            m_instr   = 32'h0;
            m_pc_out  = RST_PC;
            m_pc      = RST_PC;
            m_addr    = RST_PC;
        end else if (m_valid) begin
            // Presenting to decode: leave on redirect or on consumption.
            if (redirect) begin
                m_pc    = tgt;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
        end else if (m_req) begin
            if (imem_ack) begin
                if (!m_discard && !redirect) begin
                    m_instr  = imem_rdata;
                    m_pc_out = m_addr;
                    m_pc     = m_addr + 32'd4;
                    m_valid  = 1'b1;
                end else if (redirect) begin
                    m_pc = tgt;
                end
                m_req     = 1'b0;
                m_discard = 1'b0;
            end else if (redirect) begin
                m_pc      = tgt;
                m_discard = 1'b1;
            end
        end else begin
            // Idle cycle before a request: the request starts at the edge.
            m_addr = redirect ? tgt : m_pc;
            if (redirect) m_pc = tgt;
            m_req     = 1'b1;
            m_discard = 1'b0;
        end
    endtask

    // Advance one clock. Update the model, let outputs settle, then drive the
    // auto-ack memory for the coming cycle.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0;
            end
            wait_cnt++;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            wait_cnt   = 0;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Single compare process: the DUT against the model on every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("imem_req", 32'(imem_req), 32'(m_req));
            if (m_req) check("imem_addr", imem_addr, m_addr);
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("instr", instr, m_instr);
            check("pc_out", pc_out, m_pc_out);
            check("pcplus4", pcplus4, m_pc_out + 32'd4);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        logic [31:0] p4s[$];
        logic [31:0] ins[$];
        logic [31:0] held;
        int          req_hi, addr_ok, vcnt;

        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;

        // ---- 1: zero-wait streaming from reset ----
        ack_delay = 0;
        do_reset();
        check("t1 reset instr_valid", 32'(instr_valid), 32'd0);
        check("t1 reset imem_req", 32'(imem_req), 32'd0);
        check("t1 reset pc_out", pc_out, 32'h0);
        for (int i = 0; i < 9; i++) begin
            step();
            if (imem_req) addrs.push_back(imem_addr);
            if (instr_valid) begin
                pcs.push_back(pc_out);
                p4s.push_back(pcplus4);
                ins.push_back(instr);
            end
        end
        check("t1 req count", 32'(addrs.size()), 32'd3);
        check("t1 valid count", 32'(pcs.size()), 32'd3);
        if (addrs.size() == 3 && pcs.size() == 3) begin
            check("t1 addr0", addrs[0], 32'h0);
            check("t1 addr1", addrs[1], 32'h4);
            check("t1 addr2", addrs[2], 32'h8);
            check("t1 pc0", pcs[0], 32'h0);
            check("t1 pc2", pcs[2], 32'h8);
            check("t1 p4_0", p4s[0], 32'h4);
            check("t1 p4_2", p4s[2], 32'hC);
            check("t1 instr1", ins[1], mem_word(32'h4));
        end

        // ---- 2: ack delayed by three cycles at 0x10 ----
        do_reset();
        ack_delay   = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        req_hi  = 0;
        addr_ok = 0;
        vcnt    = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req) req_hi++;
            if (imem_req && imem_addr == 32'h10) addr_ok++;
            if (instr_valid) vcnt++;
            step();
        end
        check("t2 req cycles", 32'(req_hi), 32'd4);
        check("t2 addr stable", 32'(addr_ok), 32'd4);
        check("t2 out cycles", 32'(vcnt), 32'd1);

        // ---- 3: stall holds OUT for five cycles ----
        ack_delay = 0;
        do_reset();
        stall = 1'b1;
        step();
        step();
        held = instr;
        check("t3 held instr", held, mem_word(32'h0));
        for (int i = 0; i < 5; i++) begin
            check("t3 stall valid", 32'(instr_valid), 32'd1);
            check("t3 stall instr", instr, held);
            check("t3 stall pc_out", pc_out, 32'h0);
            check("t3 stall req", 32'(imem_req), 32'd0);
            if (i < 4) step();
        end
        stall = 1'b0;
        step();
        step();
        check("t3 next req", 32'(imem_req), 32'd1);
        check("t3 next addr", imem_addr, 32'h4);

        // ---- 4: redirect to 0x103 while a request is pending ----
        ack_delay = 1000;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        check("t4 flush req", 32'(imem_req), 32'd1);
        check("t4 flush addr", imem_addr, 32'h0);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        check("t4 stale not valid", 32'(instr_valid), 32'd0);
        ack_delay = 0;
        step();
        check("t4 new addr", imem_addr, 32'h100);
        check("t4 no valid yet", 32'(instr_valid), 32'd0);
        step();
        check("t4 good valid", 32'(instr_valid), 32'd1);
        check("t4 good instr", instr, mem_word(32'h100));
        check("t4 good pc", pc_out, 32'h100);

        // ---- 5: redirect with ack in FETCH; redirect with stall in OUT ----
        ack_delay = 0;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("t5 no valid", 32'(instr_valid), 32'd0);
        step();
        check("t5 addr 200", imem_addr, 32'h200);
        check("t5 still no valid", 32'(instr_valid), 32'd0);
        step();
        check("t5 out valid", 32'(instr_valid), 32'd1);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        check("t5 redirect beats stall", 32'(instr_valid), 32'd0);
        step();
        check("t5 addr 300", imem_addr, 32'h300);

        // ---- 6: reset in FLUSH with ack; PC wrap ----
        ack_delay = 1000;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect   = 1'b0;
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        check("t6 rst req", 32'(imem_req), 32'd0);
        check("t6 rst valid", 32'(instr_valid), 32'd0);
        check("t6 rst instr", instr, 32'h0);
        check("t6 rst pc_out", pc_out, RST_PC);
        check("t6 rst pcplus4", pcplus4, 32'h4);
        reset = 1'b0;
        step();
        check("t6 refetch addr", imem_addr, RST_PC);

        ack_delay = 0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        check("t6 top addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("t6 top pc_out", pc_out, 32'hFFFF_FFFC);
        check("t6 wrap pcplus4", pcplus4, 32'h0);
        step();
        step();
        check("t6 wrap addr", imem_addr, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
